// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
// Requester count, select width and FSM state encoding.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] gnt;
  logic               out_valid;
  logic               busy;

  modport master (
    output req,
    input  sel, gnt, out_valid, busy
  );

  modport slave (
    input  req,
    output sel, gnt, out_valid, busy
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotated priority scan: first set req after last, cyclically.
// Purely combinational.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   win
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     sh;
  logic [SEL_W-1:0]     off;

  // rotate so bit 0 is the requester right after last
  always_comb begin
    dbl = {req, req};
    sh  = last + SEL_W'(1);
    rot = NUM_REQ'(dbl >> sh);
    off = '0;
    priority case (1'b1)
      rot[0]:  off = SEL_W'(0);
      rot[1]:  off = SEL_W'(1);
      rot[2]:  off = SEL_W'(2);
      rot[3]:  off = SEL_W'(3);
      default: off = '0;
    endcase
  end

  assign any = |req;
  assign win = sh + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 16-bit mux.
// Bounded hold per grant, one idle cycle between grants.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 3
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [SEL_W-1:0]     last, last_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 any;
  logic [SEL_W-1:0]     win;
  logic                 rel;
  logic                 start;
  logic                 hold;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last),
    .any  (any),
    .win  (win)
  );

  assign rel   = (cnt == CNT_W'(HOLD_CYC - 1)) || !bus.req[sel_q];
  assign start = (state == ST_IDLE) && any;
  assign hold  = (state == ST_GRANT) && !rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= SEL_W'(NUM_REQ - 1);
      sel_q <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      last  <= last_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (any) state_d = ST_GRANT;
      ST_GRANT: if (rel) state_d = ST_IDLE;
    endcase
  end

  // sel keeps its value in IDLE so the mux output never glitches
  always_comb begin
    cnt_d  = '0;
    last_d = last;
    sel_d  = sel_q;
    gnt_d  = '0;
    unique case (1'b1)
      start: begin
        gnt_d  = NUM_REQ'(1) << win;
        sel_d  = win;
        last_d = win;
      end
      hold: begin
        gnt_d = gnt_q;
        cnt_d = cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = (state == ST_GRANT);
  assign bus.busy      = (state == ST_GRANT) || (|bus.req);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: HOLD_CYC=4 and HOLD_CYC=1 instances,
// directed pins plus randomized traffic against a queue-free owner model.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  mux4_rr_arbiter_if ifa ();
  mux4_rr_arbiter_if ifb ();

  mux4_rr_arbiter #(.HOLD_CYC(4), .CNT_W(3)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  mux4_rr_arbiter #(.HOLD_CYC(1), .CNT_W(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: who owns the bus, for how many cycles so far, who won last
  int own   [2];
  int age   [2];
  int mlast [2];
  int msel  [2];
  int run   [2];
  int hold  [2] = '{4, 1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        own[k]   = -1;
        age[k]   = 0;
        mlast[k] = 3;
        msel[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] r;
        r = (k == 0) ? ifa.req : ifb.req;
        if (own[k] < 0) begin
          for (int j = 1; j <= 4; j++)
            if (own[k] < 0 && r[(mlast[k] + j) % 4])
              own[k] = (mlast[k] + j) % 4;
          if (own[k] >= 0) begin
            age[k]   = 1;
            mlast[k] = own[k];
            msel[k]  = own[k];
          end
        end else if (age[k] >= hold[k] || !r[own[k]]) begin
          own[k] = -1;
        end else begin
          age[k]++;
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [3:0] g, input logic [1:0] s,
                     input logic ov, input logic bz, input logic [3:0] r);
    string pf;
    int eg;
    pf = (k == 0) ? "A" : "B";
    eg = (own[k] < 0) ? 0 : (1 << own[k]);
    chk({pf, ".gnt"}, int'(g), eg);
    chk({pf, ".sel"}, int'(s), msel[k]);
    chk({pf, ".out_valid"}, int'(ov), int'(own[k] >= 0));
    chk({pf, ".busy"}, int'(bz), int'(own[k] >= 0 || r != 4'b0));
    chk({pf, ".onehot0"}, int'($onehot0(g)), 1);
    chk({pf, ".gnt_sel"}, int'(g[s]), int'(ov));
    if (g != 4'b0) run[k]++;
    else run[k] = 0;
    chk({pf, ".hold_max"}, int'(run[k] <= hold[k]), 1);
  endtask

  always @(negedge clk) begin
    cmp(0, ifa.gnt, ifa.sel, ifa.out_valid, ifa.busy, ifa.req);
    cmp(1, ifb.gnt, ifb.sel, ifb.out_valid, ifb.busy, ifb.req);
  end

  task automatic cyc(input logic [3:0] r);
    @(posedge clk);
    #1;
    ifa.req = r;
    ifb.req = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    ifa.req = 4'b0;
    ifb.req = 4'b0;
    #1;
    chk("rst.gnt", int'(ifa.gnt), 0);
    chk("rst.sel", int'(ifa.sel), 0);
    chk("rst.ov", int'(ifa.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] e1 [21] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
    4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
    4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
    4'b0001
  };
  logic [1:0] s1 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    checks  = 0;
    fails   = 0;
    run     = '{0, 0};
    rst_n   = 1'b0;
    ifa.req = 4'b0;
    ifb.req = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all four requesting: 0,1,2,3,0 with 4-cycle holds
    do_reset();
    ifa.req = 4'b1111;
    ifb.req = 4'b1111;
    for (int i = 0; i < 21; i++) begin
      cyc(4'b1111);
      chk($sformatf("t1.gnt[%0d]", i), int'(ifa.gnt), int'(e1[i]));
      if (i % 5 == 0 && i < 20)
        chk($sformatf("t1.sel[%0d]", i), int'(ifa.sel), int'(s1[i / 5]));
    end

    // two-cycle pulse on requester 2
    do_reset();
    cyc(4'b0100);
    cyc(4'b0100);
    chk("t2.gnt0", int'(ifa.gnt), 4'b0100);
    cyc(4'b0000);
    chk("t2.gnt1", int'(ifa.gnt), 4'b0100);
    cyc(4'b0000);
    chk("t2.gnt2", int'(ifa.gnt), 0);
    cyc(4'b0000);
    chk("t2.gnt3", int'(ifa.gnt), 0);
    chk("t2.sel", int'(ifa.sel), 2);

    // withdrawal of requester 1 at cnt=1, then 3 after one idle
    do_reset();
    cyc(4'b1010);
    cyc(4'b1010);
    chk("t3.gnt0", int'(ifa.gnt), 4'b0010);
    cyc(4'b1000);
    chk("t3.gnt1", int'(ifa.gnt), 4'b0010);
    cyc(4'b1000);
    chk("t3.gnt2", int'(ifa.gnt), 0);
    cyc(4'b1000);
    chk("t3.gnt3", int'(ifa.gnt), 4'b1000);
    chk("t3.sel", int'(ifa.sel), 3);

    // async reset in the middle of requester 2's grant
    do_reset();
    cyc(4'b0100);
    cyc(4'b0100);
    cyc(4'b0100);
    chk("t4.pre", int'(ifa.gnt), 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4.gnt", int'(ifa.gnt), 0);
    chk("t4.sel", int'(ifa.sel), 0);
    chk("t4.ov", int'(ifa.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    ifa.req = 4'b1111;
    ifb.req = 4'b1111;
    cyc(4'b1111);
    chk("t4.first", int'(ifa.gnt), 4'b0001);

    // HOLD_CYC=1 instance alternates 1 and 3 with idle gaps
    do_reset();
    cyc(4'b1010);
    cyc(4'b1010);
    chk("t5.g0", int'(ifb.gnt), 4'b0010);
    cyc(4'b1010);
    chk("t5.g1", int'(ifb.gnt), 0);
    chk("t5.ov1", int'(ifb.out_valid), 0);
    cyc(4'b1010);
    chk("t5.g2", int'(ifb.gnt), 4'b1000);
    chk("t5.ov2", int'(ifb.out_valid), 1);
    cyc(4'b1010);
    chk("t5.g3", int'(ifb.gnt), 0);
    cyc(4'b1010);
    chk("t5.g4", int'(ifb.gnt), 4'b0010);

    // randomized traffic with sticky requests and rare resets
    do_reset();
    begin
      logic [3:0] r;
      r = 4'b0;
      for (int c = 0; c < 3000; c++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if ($urandom_range(0, 99) == 0) r = 4'b1111;
        cyc(r);
        if ($urandom_range(0, 299) == 0) begin
          #2;
          rst_n = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
